// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction fetch with in-order prefetch queue and redirect flush
// Define IFQ_BYPASS_EN to let a response reach the decoder in its arrival cycle when the queue is empty.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IGnt,
    input  logic        IRvalid,
    input  logic [31:0] IRdata,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];
    logic [CW:0]   credit;
    logic          head_valid, byp, grant, push, pop;
    logic          unused_bits;

    assign unused_bits = ^RedirectPC[1:0];
    assign head_valid  = (count_q != '0);

    // Queued entries plus in-flight fetches never exceed DEPTH, so a response always has a slot.
    assign credit = {1'b0, count_q} + {1'b0, outst_q};
    assign IReq   = !reset && !Redirect && (credit < DEPTH_W);
    assign IAddr  = fpc_q;
    assign grant  = IReq && IGnt;

    always_comb begin
        byp        = 1'b0;
        InstrValid = head_valid && !Redirect && !reset;
        Instr      = head_valid ? ins_mem_q[head_q] : '0;
        InstrPC    = head_valid ? pc_mem_q[head_q]  : '0;
`ifdef IFQ_BYPASS_EN
        if (!head_valid && drop_q == '0 && !Redirect && !reset && IRvalid) begin
            byp        = 1'b1;
            InstrValid = 1'b1;
            Instr      = IRdata;
            InstrPC    = rpc_q;
        end
`endif
    end

    assign pop  = head_valid && InstrValid && InstrReady;
    assign push = IRvalid && (drop_q == '0) && !Redirect && !(byp && InstrReady);

    always_comb begin
        fpc_d   = fpc_q;
        rpc_d   = rpc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (Redirect) begin
            // Everything still in flight belongs to the old path, except a response landing right now.
            fpc_d   = {RedirectPC[31:2], 2'b00};
            rpc_d   = {RedirectPC[31:2], 2'b00};
            outst_d = outst_q - CW'(IRvalid);
            drop_d  = outst_q - CW'(IRvalid);
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (grant) begin
                fpc_d = fpc_q + 32'd4;
            end
            outst_d = outst_q + CW'(grant) - CW'(IRvalid);
            if (IRvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    rpc_d = rpc_q + 32'd4;
                end
            end
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem_q[tail_q]  <= rpc_q;
            ins_mem_q[tail_q] <= IRdata;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue with an in-order latency memory model
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        reset, IReq, IGnt, IRvalid, Redirect, InstrValid, InstrReady;
    logic [31:0] IAddr, IRdata, RedirectPC, Instr, InstrPC;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt),
        .IRvalid(IRvalid), .IRdata(IRdata), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC)
    );

`ifdef IFQ_BYPASS_EN
    localparam int NB = 0;
`else
    localparam int NB = 1;
`endif

    int checks = 0;
    int failures = 0;

    logic        rst = 1'b1, gnt_en = 1'b0, rdy_en = 1'b0, redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        o_ireq, o_ivalid;
    logic [31:0] o_instr, o_ipc;
    logic [31:0] exp_fetch = '0, exp_pc = '0, first_pc = '0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          lat = 1, cyc = 0, pops = 0, grants = 0, first_valid = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    task automatic step();
        @(negedge clk);
        reset      = rst;
        IGnt       = gnt_en;
        InstrReady = rdy_en;
        Redirect   = redir;
        RedirectPC = redir_pc;
        IRvalid    = 1'b0;
        IRdata     = '0;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            IRvalid = 1'b1;
            IRdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        o_ireq   = IReq;
        o_ivalid = InstrValid;
        o_instr  = Instr;
        o_ipc    = InstrPC;
        if (IReq && IGnt) begin
            check_eq("iaddr", IAddr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            pend_addr.push_back(IAddr);
            pend_due.push_back(cyc + lat);
            grants++;
        end
        if (InstrValid && InstrReady) begin
            check_eq("instr_pc", InstrPC, exp_pc);
            check_eq("instr_data", Instr, mem_word(exp_pc));
            if (first_valid < 0) begin
                first_valid = cyc;
                first_pc    = InstrPC;
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir) begin
            exp_fetch = {redir_pc[31:2], 2'b00};
            exp_pc    = {redir_pc[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        redir = 1'b0;
        step();
        check_eq("rst_ireq_a", 32'(o_ireq), 32'd0);
        check_eq("rst_ivalid_a", 32'(o_ivalid), 32'd0);
        step();
        check_eq("rst_ireq_b", 32'(o_ireq), 32'd0);
        check_eq("rst_ivalid_b", 32'(o_ivalid), 32'd0);
        check_eq("rst_instr", o_instr, 32'd0);
        check_eq("rst_instr_pc", o_ipc, 32'd0);
        rst         = 1'b0;
        exp_fetch   = 32'h0;
        exp_pc      = 32'h0;
        cyc         = 0;
        pops        = 0;
        first_valid = -1;
    endtask

    initial begin
        int r;
        // Streaming at full rate from reset
        lat = 1; gnt_en = 1'b1; rdy_en = 1'b1;
        do_reset();
        step();
        check_eq("first_req", 32'(o_ireq), 32'd1);
        for (int i = 1; i < 20; i++) step();
        check_eq("stream_first_valid", 32'(first_valid), 32'(1 + NB));
        check_eq("stream_pops", 32'(pops), 32'(20 - 1 - NB));

        // Back-pressure fills count+outst to DEPTH
        rdy_en = 1'b0;
        grants = 0;
        for (int i = 0; i < 10; i++) step();
        check_eq("stall_grants", 32'(grants), 32'(3 - NB));
        check_eq("stall_ireq", 32'(o_ireq), 32'd0);
        check_eq("stall_ivalid", 32'(o_ivalid), 32'd1);
        rdy_en = 1'b1;
        pops = 0;
        for (int i = 0; i < 12; i++) step();
        check_eq("release_pops", 32'(pops > 8), 32'd1);

        // Redirect with two responses in flight, L=3
        lat = 3;
        do_reset();
        step();
        step();
        gnt_en = 1'b1; redir = 1'b1; redir_pc = 32'h0000_0103;
        r = cyc;
        step();
        check_eq("redir_ireq", 32'(o_ireq), 32'd0);
        redir = 1'b0; first_valid = -1;
        step();
        check_eq("redir_next_req", 32'(o_ireq), 32'd1);
        for (int i = 0; i < 12; i++) step();
        check_eq("redir_first_pc", first_pc, 32'h0000_0100);
        check_eq("redir_latency", 32'(first_valid), 32'(r + 1 + 3 + NB));

        // Redirect colliding with a response and a pop, L=2
        lat = 2;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        redir = 1'b1; redir_pc = 32'h0000_0200;
        r = cyc;
        step();
        check_eq("coll_ivalid", 32'(o_ivalid), 32'd0);
        check_eq("coll_ireq", 32'(o_ireq), 32'd0);
        redir = 1'b0; first_valid = -1;
        for (int i = 0; i < 12; i++) step();
        check_eq("coll_first_pc", first_pc, 32'h0000_0200);
        check_eq("coll_latency", 32'(first_valid), 32'(r + 1 + 2 + NB));

        // Fetch address wraps at the top of the address space
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        step();
        redir = 1'b0; first_valid = -1;
        for (int i = 0; i < 8; i++) step();
        check_eq("wrap_first_pc", first_pc, 32'hFFFF_FFFC);
        check_eq("wrap_next_pc", exp_pc > 32'h0000_0004 && exp_pc < 32'h0000_0100 ? 32'd1 : 32'd0, 32'd1);

        // Reset with a full queue
        rdy_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("full_ireq", 32'(o_ireq), 32'd0);
        rdy_en = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("restart_pops", 32'(pops), 32'(10 - 1 - NB));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
